// File: rtl/reg_bank.sv
// reg_bank: small register file on a shared tri-state bus, with in-place
// inc/dec/clr operations, per-register zero flags, a carry flag and a
// one-cycle error pulse.
// Optional feature macro: REG_BANK_SHIFT_EN enables the shl/shr operations.
// Without it, shift opcodes are rejected like the reserved ones.
module reg_bank #(
    parameter int DATA_W   = 8,
    parameter int NUM_REGS = 4,
    parameter int IDX_W    = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    inout  wire logic [DATA_W-1:0]       bus,
    input  logic                         wr_en,
    input  logic [IDX_W-1:0]             wr_idx,
    input  logic                         rd_en,
    input  logic [IDX_W-1:0]             rd_idx,
    input  logic [2:0]                   op,
    input  logic [IDX_W-1:0]             op_idx,
    output logic [NUM_REGS*DATA_W-1:0]   reg_flat,
    output logic [NUM_REGS-1:0]          zero,
    output logic                         carry,
    output logic                         err
);

    localparam logic [2:0] OP_NONE = 3'b000;
    localparam logic [2:0] OP_INC  = 3'b001;
    localparam logic [2:0] OP_DEC  = 3'b010;
    localparam logic [2:0] OP_CLR  = 3'b011;
    localparam logic [2:0] OP_SHL  = 3'b100;
    localparam logic [2:0] OP_SHR  = 3'b101;

    localparam logic [IDX_W:0] NUM_REGS_W = (IDX_W+1)'(NUM_REGS);

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];
    logic              carry_q, carry_d;
    logic              err_q, err_d;

    logic              wr_valid, rd_valid, op_valid;
    logic              bus_oe;
    logic              wr_ok;
    logic [DATA_W-1:0] rd_data;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] cur;

    // Index range checks; out-of-range indices only matter when NUM_REGS < 2**IDX_W.
    always_comb begin
        wr_valid = {1'b0, wr_idx} < NUM_REGS_W;
        rd_valid = {1'b0, rd_idx} < NUM_REGS_W;
        op_valid = {1'b0, op_idx} < NUM_REGS_W;
    end

    // Read path: selected register, driven onto the bus only while not in reset.
    always_comb begin
        rd_data = '0;
        if (rd_valid) rd_data = regs_q[rd_idx];
        bus_oe  = rd_en && rd_valid && !rst;
    end

    assign bus = bus_oe ? rd_data : {DATA_W{1'bz}};

    // Next-state: operation, then write (write wins on a shared index), plus fault collection.
    always_comb begin
        regs_d  = regs_q;
        carry_d = carry_q;
        err_d   = 1'b0;
        cur     = '0;
        // A move takes the source value directly rather than resolving it back off the bus.
        wr_data = (rd_en && rd_valid) ? rd_data : bus;
        wr_ok   = wr_en && wr_valid && !(rd_en && (rd_idx == wr_idx));

        if (wr_en && !wr_valid) err_d = 1'b1;
        if (rd_en && !rd_valid) err_d = 1'b1;
        if (wr_en && rd_en && (rd_idx == wr_idx)) err_d = 1'b1;

        if (op != OP_NONE) begin
            if (!op_valid || (wr_en && (wr_idx == op_idx))) begin
                err_d = 1'b1;
            end else begin
                cur = regs_q[op_idx];
                case (op)
                    OP_INC: begin
                        regs_d[op_idx] = cur + DATA_W'(1);
                        carry_d        = &cur;
                    end
                    OP_DEC: begin
                        regs_d[op_idx] = cur - DATA_W'(1);
                        carry_d        = ~|cur;
                    end
                    OP_CLR: begin
                        regs_d[op_idx] = '0;
                    end
`ifdef REG_BANK_SHIFT_EN
                    OP_SHL: begin
                        regs_d[op_idx] = {cur[DATA_W-2:0], 1'b0};
                        carry_d        = cur[DATA_W-1];
                    end
                    OP_SHR: begin
                        regs_d[op_idx] = {1'b0, cur[DATA_W-1:1]};
                        carry_d        = cur[0];
                    end
`else
                    OP_SHL, OP_SHR: begin
                        err_d = 1'b1;
                    end
`endif
                    default: begin
                        err_d = 1'b1;
                    end
                endcase
            end
        end

        if (wr_ok) regs_d[wr_idx] = wr_data;
    end

    // State registers with synchronous reset; reset discards any pending write or op.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
            carry_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            regs_q  <= regs_d;
            carry_q <= carry_d;
            err_q   <= err_d;
        end
    end

    // Flattened register view and per-register zero flags.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            reg_flat[i*DATA_W +: DATA_W] = regs_q[i];
            zero[i]                      = (regs_q[i] == '0);
        end
    end

    assign carry = carry_q;
    assign err   = err_q;

endmodule

// File: doc/reg_bank.md
REG_BANK -- requirements
Module: reg_bank

Interface
REQ-001 SHALL have parameter DATA_W, default 8, register and bus width.
REQ-002 SHALL have parameter NUM_REGS, default 4, register count (2..16).
REQ-003 SHALL have parameter IDX_W, default 2, index width, ceil(log2(NUM_REGS)).
REQ-004 SHALL have port clk  input  1  sole clock; one clock; reset is synchronous and active-high.
REQ-005 SHALL have port rst  input  1  synchronous active-high reset.
REQ-006 SHALL have port bus  inout  DATA_W  shared tri-state system bus.
REQ-007 SHALL have port wr_en  input  1  load register wr_idx from bus.
REQ-008 SHALL have port wr_idx  input  IDX_W  destination index.
REQ-009 SHALL have port rd_en  input  1  drive register rd_idx onto bus.
REQ-010 SHALL have port rd_idx  input  IDX_W  source index.
REQ-011 SHALL have port op  input  3  in-place operation: 000 none, 001 inc, 010 dec, 011 clr, 100 shl, 101 shr, 110/111 reserved.
REQ-012 SHALL have port op_idx  input  IDX_W  operation target index.
REQ-013 SHALL have port reg_flat  output  NUM_REGS*DATA_W  all register contents, reg i at bits [i*DATA_W +: DATA_W].
REQ-014 SHALL have port zero  output  NUM_REGS  bit i high when reg i == 0.
REQ-015 SHALL have port carry  output  1  registered carry/borrow/shift-out flag.
REQ-016 SHALL have port err  output  1  registered one-cycle error pulse.

Function
REQ-017 SHALL drive bus with reg[rd_idx] combinationally while rd_en=1 and rd_idx<NUM_REGS, else high-Z.
REQ-018 SHALL load reg[wr_idx] from bus on the clk rising edge when wr_en=1; one-cycle latency to reg_flat.
REQ-019 SHALL treat rd_en=1, wr_en=1, rd_idx!=wr_idx as a move: dst gets src's pre-edge value in one cycle.
REQ-020 SHALL suppress the write and pulse err when rd_en=1, wr_en=1 and rd_idx==wr_idx.
REQ-021 SHALL perform inc/dec modulo 2^DATA_W; carry set on wrap (all-ones->0 inc, 0->all-ones dec), else cleared by that op.
REQ-022 SHALL clear the register on clr; carry unchanged.
REQ-023 SHALL hold carry when no inc/dec/shift executes.
REQ-024 SHALL give a write priority over op on the same index in the same cycle; op dropped, err pulsed.
REQ-025 SHALL execute write and op in the same cycle when indices differ.
REQ-026 SHALL ignore any write, read drive or op whose index >= NUM_REGS and pulse err.
REQ-027 SHALL treat op 110/111 as no-op and pulse err.
REQ-028 SHALL compute zero combinationally from current register contents.
REQ-029 SHALL assert err for exactly the cycle after the offending edge; multiple faults in one cycle give one pulse.

Reset
REQ-030 SHALL, on rst=1 at a clk edge, clear all registers, carry and err; zero = all ones; bus high-Z while rst=1.
REQ-031 SHALL give rst priority over wr_en/op in the same cycle; in-flight move discarded.

Configuration
REQ-032 SHALL, with REG_BANK_SHIFT_EN defined, implement shl (carry=old MSB, LSB=0) and shr (carry=old LSB, MSB=0).
REQ-033 SHALL, without REG_BANK_SHIFT_EN, treat 100/101 as no-op with err pulse; no shift logic synthesized.

Verification
REQ-034 Bus load: bench drives 8'hAF, wr_en=1 wr_idx=2 one cycle -> reg 2 = AF next cycle, zero[2]=0, others 0.
REQ-035 Move: reg1=5A, rd_en rd_idx=1, wr_en wr_idx=3 -> bus=5A same cycle, reg3=5A next cycle, reg1 unchanged.
REQ-036 Wrap: reg0=FF, op=inc idx0 -> reg0=00, carry=1, zero[0]=1; then op=dec -> FF, carry=1; inc on 01 -> 02, carry=0.
REQ-037 Conflict: wr_en idx2 with bus=11 and op=clr idx2 same cycle -> reg2=11, err=1 one cycle; rd/wr same idx 1 -> reg1 unchanged, err=1.
REQ-038 Shift: macro on, reg0=81, op=shl -> 02, carry=1; macro off, same stimulus -> reg0=81, err=1.
REQ-039 Reset mid-move: rst=1 with wr_en/rd_en move active -> all regs 0, carry=0, err=0, bus high-Z.
